// File: rtl/biu_master.sv
// Bus interface unit master: turns single client requests into one-cycle
// tri-state bus transactions and waits for the slave's reply or a read timeout.
module biu_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    inout  wire  [ADDR_WIDTH-1:0] bus_address,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    inout  wire  [1:0]            bus_control,
    input  logic                  biu_en,
    input  logic                  biu_rnw,
    input  logic [ADDR_WIDTH-1:0] biu_address,
    input  logic [DATA_WIDTH-1:0] biu_data_in,
    output logic [DATA_WIDTH-1:0] biu_data_out,
    output logic                  biu_data_valid,
    output logic                  biu_error,
    output logic                  biu_busy
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        SEND_REQ = 3'b010,
        WAIT_RSP = 3'b100
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rnw_q, rnw_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  data_valid_d;
    logic                  error_d;
    logic                  rsp_seen;
    logic                  drive;

    // The master owns the bus only while issuing the request; the slave uses it otherwise.
    assign drive       = (state == SEND_REQ);
    assign bus_address = drive ? address_q : 'z;
    assign bus_data    = drive ? data_q : 'z;
    assign bus_control = drive ? {rnw_q, 1'b1} : 2'bzz;

    // A floating or partially driven control field never compares equal, so it reads as no response.
    assign rsp_seen = (bus_control == 2'b11);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        address_d    = address_q;
        data_d       = data_q;
        rnw_d        = rnw_q;
        cnt_d        = cnt_q;
        data_out_d   = biu_data_out;
        data_valid_d = 1'b0;
        error_d      = 1'b0;
        case (state)
            IDLE: begin
                if (biu_en) begin
                    address_d = biu_address;
                    data_d    = biu_data_in;
                    rnw_d     = biu_rnw;
                    state_d   = SEND_REQ;
                end
            end
            SEND_REQ: begin
                cnt_d   = '0;
                state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                // Response wins over timeout when both land in the same cycle.
                if (!rnw_q) begin
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end else if (rsp_seen) begin
                    data_out_d   = bus_data;
                    data_valid_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            address_q      <= '0;
            data_q         <= '0;
            rnw_q          <= 1'b0;
            cnt_q          <= '0;
            biu_data_out   <= '0;
            biu_data_valid <= 1'b0;
            biu_error      <= 1'b0;
            biu_busy       <= 1'b0;
        end else begin
            address_q      <= address_d;
            data_q         <= data_d;
            rnw_q          <= rnw_d;
            cnt_q          <= cnt_d;
            biu_data_out   <= data_out_d;
            biu_data_valid <= data_valid_d;
            biu_error      <= error_d;
            biu_busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_biu_master.sv
// Self-checking bench for biu_master: a behavioural slave on a pulled-down bus
// and a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_biu_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          biu_en = 1'b0;
    logic          biu_rnw = 1'b0;
    logic [AW-1:0] biu_address = '0;
    logic [DW-1:0] biu_data_in = '0;
    logic [DW-1:0] biu_data_out;
    logic          biu_data_valid;
    logic          biu_error;
    logic          biu_busy;

    tri0 [AW-1:0]  bus_address;
    tri0 [DW-1:0]  bus_data;
    tri0 [1:0]     bus_control;

    // Slave model state
    logic          slv_drive = 1'b0;
    logic [DW-1:0] slv_rdata = '0;
    int            slv_wait = 0;
    logic          rsp_pending = 1'b0;
    int            rsp_cnt = 0;
    int            bus_txn_cnt = 0;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [DW-1:0] exp_data_out = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign bus_data    = slv_drive ? slv_rdata : 'z;
    assign bus_control = slv_drive ? 2'b11 : 2'bzz;

    biu_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .bus_address    (bus_address),
        .bus_data       (bus_data),
        .bus_control    (bus_control),
        .biu_en         (biu_en),
        .biu_rnw        (biu_rnw),
        .biu_address    (biu_address),
        .biu_data_in    (biu_data_in),
        .biu_data_out   (biu_data_out),
        .biu_data_valid (biu_data_valid),
        .biu_error      (biu_error),
        .biu_busy       (biu_busy)
    );

    // Slave: sees a request mid-cycle, answers reads (unless unmapped) for one cycle
    // starting slv_wait cycles after the turnaround cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!slv_drive && bus_control[0] === 1'b1) begin
                bus_txn_cnt++;
                if (bus_control[1] === 1'b1 && bus_address[31:16] != 16'hFFFF) begin
                    rsp_pending = 1'b1;
                    rsp_cnt     = slv_wait + 2;
                end
            end
            @(posedge clk);
            #1;
            if (slv_drive) slv_drive = 1'b0;
            if (rsp_pending) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    slv_drive   = 1'b1;
                    rsp_pending = 1'b0;
                end
            end
        end
    end

    // Present a request from a negedge so it is sampled on the next rising edge (cycle 0).
    task automatic drive_req(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        biu_en      = 1'b1;
        biu_rnw     = rnw;
        biu_address = addr;
        biu_data_in = wdata;
        @(posedge clk);
        #1;
        biu_en = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (biu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", biu_busy); end
        checks++; if (biu_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", biu_data_valid); end
        checks++; if (biu_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", biu_error); end
        checks++; if (biu_data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", biu_data_out); end
        checks++; if (bus_control !== 2'b00 || bus_address !== '0) begin errors++; $display("FAIL reset_bus got=%h/%b exp=0/00", bus_address, bus_control); end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b0, 32'h4, 32'hDEADBEEF);
        @(negedge clk); // cycle 1
        checks++; if (bus_address !== 32'h4 || bus_data !== 32'hDEADBEEF || bus_control !== 2'b01) begin
            errors++; $display("FAIL wr_bus_c1 got=%h/%h/%b exp=4/deadbeef/01", bus_address, bus_data, bus_control); end
        checks++; if (biu_busy !== 1'b1 || biu_data_valid !== 1'b0) begin errors++; $display("FAIL wr_c1 busy/valid got=%b%b exp=10", biu_busy, biu_data_valid); end
        @(negedge clk); // cycle 2
        checks++; if (bus_control !== 2'b00 || bus_data !== '0 || bus_address !== '0) begin
            errors++; $display("FAIL wr_bus_c2 got=%h/%h/%b exp=released", bus_address, bus_data, bus_control); end
        checks++; if (biu_busy !== 1'b1 || biu_data_valid !== 1'b0) begin errors++; $display("FAIL wr_c2 busy/valid got=%b%b exp=10", biu_busy, biu_data_valid); end
        @(negedge clk); // cycle 3
        checks++; if (biu_data_valid !== 1'b1 || biu_busy !== 1'b0 || biu_error !== 1'b0) begin
            errors++; $display("FAIL wr_c3 valid/busy/err got=%b%b%b exp=100", biu_data_valid, biu_busy, biu_error); end
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL wr_sb_empty got=0 entries exp=1"); end
        else begin
            e = sb.pop_front();
            checks++; if (biu_data_out !== e.data) begin errors++; $display("FAIL wr_data_out got=%h exp=%h", biu_data_out, e.data); end
        end
        @(negedge clk); // cycle 4
        checks++; if (biu_data_valid !== 1'b0) begin errors++; $display("FAIL wr_c4_valid got=%b exp=0", biu_data_valid); end
    endtask

    task automatic test_read_zero_wait();
        slv_rdata = 32'h12345678;
        slv_wait  = 0;
        exp_data_out = 32'h12345678;
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b1, 32'h8, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (bus_address !== 32'h8 || bus_control !== 2'b11) begin
                    errors++; $display("FAIL rd0_req got=%h/%b exp=8/11", bus_address, bus_control); end
            end
            checks++; if (biu_error !== 1'b0) begin errors++; $display("FAIL rd0_error c%0d got=%b exp=0", c, biu_error); end
            checks++; if (biu_data_valid !== (c == 4)) begin errors++; $display("FAIL rd0_valid c%0d got=%b exp=%b", c, biu_data_valid, c == 4); end
            if (c == 4) begin
                if (sb.size() == 0) begin checks++; errors++; $display("FAIL rd0_sb_empty got=0 entries exp=1"); end
                else begin
                    e = sb.pop_front();
                    checks++; if (biu_data_out !== e.data || e.err !== 1'b0) begin errors++; $display("FAIL rd0_data got=%h exp=%h", biu_data_out, e.data); end
                end
            end
        end
    endtask

    task automatic test_read_wait_state();
        slv_rdata = 32'hCAFEF00D;
        slv_wait  = 3;
        exp_data_out = 32'hCAFEF00D;
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b1, 32'h10, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++; if ($isunknown({bus_address, bus_data, bus_control})) begin
                errors++; $display("FAIL rdw_bus_x c%0d got=%h/%h/%b exp=known", c, bus_address, bus_data, bus_control); end
            checks++; if (biu_data_valid !== (c == 7) || biu_error !== 1'b0) begin
                errors++; $display("FAIL rdw_valid c%0d got=%b/%b exp=%b/0", c, biu_data_valid, biu_error, c == 7); end
            if (c == 7) begin
                if (sb.size() == 0) begin checks++; errors++; $display("FAIL rdw_sb_empty got=0 entries exp=1"); end
                else begin
                    e = sb.pop_front();
                    checks++; if (biu_data_out !== e.data) begin errors++; $display("FAIL rdw_data got=%h exp=%h", biu_data_out, e.data); end
                end
            end
        end
    endtask

    task automatic test_timeout();
        sb.push_back('{err: 1'b1, data: exp_data_out});
        drive_req(1'b1, 32'hFFFF0000, 32'h0);
        for (int c = 1; c <= TIMEOUT + 3; c++) begin
            @(negedge clk);
            if (c < TIMEOUT + 2) begin
                checks++; if (biu_error !== 1'b0 || biu_busy !== 1'b1 || biu_data_valid !== 1'b0) begin
                    errors++; $display("FAIL to_wait c%0d err/busy/valid got=%b%b%b exp=010", c, biu_error, biu_busy, biu_data_valid); end
            end else if (c == TIMEOUT + 2) begin
                checks++; if (biu_error !== 1'b1 || biu_busy !== 1'b0 || biu_data_valid !== 1'b0) begin
                    errors++; $display("FAIL to_pulse c%0d err/busy/valid got=%b%b%b exp=100", c, biu_error, biu_busy, biu_data_valid); end
                if (sb.size() == 0) begin checks++; errors++; $display("FAIL to_sb_empty got=0 entries exp=1"); end
                else begin
                    e = sb.pop_front();
                    checks++; if (biu_data_out !== e.data || e.err !== biu_error) begin
                        errors++; $display("FAIL to_data_out got=%h exp=%h", biu_data_out, e.data); end
                end
            end else begin
                checks++; if (biu_error !== 1'b0) begin errors++; $display("FAIL to_after c%0d got=%b exp=0", c, biu_error); end
            end
        end
    endtask

    task automatic test_en_ignored();
        int txn0;
        int pulses;
        txn0   = bus_txn_cnt;
        pulses = 0;
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b0, 32'h40, 32'h0000A5A5);
        // Further strobes while busy must not start or queue anything.
        biu_en = 1'b1; biu_rnw = 1'b1; biu_address = 32'h44; biu_data_in = 32'h5A5A0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        biu_en = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            if (biu_data_valid === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin checks++; errors++; $display("FAIL ign_sb_empty got=0 entries exp=1"); end
                else begin
                    e = sb.pop_front();
                    checks++; if (biu_data_out !== e.data) begin errors++; $display("FAIL ign_data_out got=%h exp=%h", biu_data_out, e.data); end
                end
            end
        end
        checks++; if (bus_txn_cnt - txn0 != 1) begin errors++; $display("FAIL ign_txns got=%0d exp=1", bus_txn_cnt - txn0); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b0, 32'h20, 32'h11111111);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); // cycle 3: completion pulse, new request presented now
        checks++; if (biu_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_wr_valid got=%b exp=1", biu_data_valid); end
        if (sb.size() != 0) e = sb.pop_front();
        slv_rdata = 32'h22222222;
        slv_wait  = 0;
        exp_data_out = 32'h22222222;
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b1, 32'h24, 32'h0);
        @(negedge clk);
        checks++; if (bus_address !== 32'h24 || bus_control !== 2'b11) begin
            errors++; $display("FAIL b2b_req got=%h/%b exp=24/11", bus_address, bus_control); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (biu_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid got=%b exp=1", biu_data_valid); end
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL b2b_sb_empty got=0 entries exp=1"); end
        else begin
            e = sb.pop_front();
            checks++; if (biu_data_out !== e.data) begin errors++; $display("FAIL b2b_data got=%h exp=%h", biu_data_out, e.data); end
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back('{err: 1'b1, data: exp_data_out});
        drive_req(1'b1, 32'hFFFF0100, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1; // cycle 3, inside WAIT_RSP
        n_rst = 1'b0;
        #1;
        sb.delete();
        exp_data_out = '0;
        checks++; if (biu_busy !== 1'b0 || biu_data_valid !== 1'b0 || biu_error !== 1'b0 || biu_data_out !== '0) begin
            errors++; $display("FAIL rstm_outputs busy/valid/err/data got=%b%b%b/%h exp=000/0", biu_busy, biu_data_valid, biu_error, biu_data_out); end
        checks++; if (bus_control !== 2'b00 || bus_data !== '0 || bus_address !== '0) begin
            errors++; $display("FAIL rstm_bus got=%h/%h/%b exp=released", bus_address, bus_data, bus_control); end
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < TIMEOUT + 2; c++) begin
            @(negedge clk);
            if (biu_error !== 1'b0 || biu_data_valid !== 1'b0) begin
                checks++; errors++; $display("FAIL rstm_stray_pulse c%0d got=%b%b exp=00", c, biu_error, biu_data_valid);
            end
        end
        checks++; if (biu_error !== 1'b0) begin errors++; $display("FAIL rstm_quiet got=%b exp=0", biu_error); end
        slv_rdata = 32'h0BADF00D;
        slv_wait  = 0;
        exp_data_out = 32'h0BADF00D;
        sb.push_back('{err: 1'b0, data: exp_data_out});
        drive_req(1'b1, 32'h30, 32'h0);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        checks++; if (biu_data_valid !== 1'b1 || biu_error !== 1'b0) begin
            errors++; $display("FAIL rstm_rd valid/err got=%b%b exp=10", biu_data_valid, biu_error); end
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL rstm_sb_empty got=0 entries exp=1"); end
        else begin
            e = sb.pop_front();
            checks++; if (biu_data_out !== e.data) begin errors++; $display("FAIL rstm_data got=%h exp=%h", biu_data_out, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_zero_wait();
        test_read_wait_state();
        test_timeout();
        test_en_ignored();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
